// File: rtl/link_list_engine.sv
`default_nettype none
// link_list_engine: NUM_LISTS singly-linked lists plus a hardware free-node pool held in one external single-port RAM.
// Optional macro LINK_LIST_LEN_EN adds per-list length registers, early range checks and the resp_len port.
module link_list_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LIST_WIDTH = 2,
  parameter int NUM_NODES  = 64,
  parameter int NODE_BASE  = 2**LIST_WIDTH,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  order_valid,
  output logic                  order_ready,
  input  logic [1:0]            order_op,
  input  logic [LIST_WIDTH-1:0] order_list,
  input  logic [IDX_WIDTH-1:0]  order_idx,
  input  logic [DATA_WIDTH-1:0] order_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_status,
  output logic [DATA_WIDTH-1:0] resp_data,
`ifdef LINK_LIST_LEN_EN
  output logic [IDX_WIDTH:0]    resp_len,
`endif
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam int NUM_LISTS = 2**LIST_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] INIT_LEN = ADDR_WIDTH'(NUM_LISTS + NUM_NODES);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [1:0] OP_INSERT = 2'b00, OP_DELETE = 2'b01, OP_WRITE = 2'b10, OP_READ = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_RANGE = 2'b01, ST_FULL = 2'b10;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_WALK_ISS, S_WALK_CAP, S_RD0_ISS, S_RD0_CAP,
    S_RD1_ISS, S_RD1_CAP, S_WR0, S_WR1, S_WR2, S_RESP
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_d, free_head, free_head_d;
  logic [ADDR_WIDTH-1:0] p, p_d, t, t_d, aux, aux_d;
  logic                  init_done_d;
  logic [1:0]            op, op_d, status, status_d;
  logic [IDX_WIDTH-1:0]  idx, idx_d, cnt, cnt_d;
  logic [DATA_WIDTH-1:0] data, data_d, rd_data, rd_data_d;
  logic [ADDR_WIDTH-1:0] addr_d, init_node, init_addr, init_link, rd_link;
  logic                  we_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  assign rd_link     = ram_rdata[ADDR_WIDTH-1:0];
  assign order_ready = (state == S_IDLE) && init_done;
  assign resp_valid  = (state == S_RESP);
  assign resp_status = status;
  assign resp_data   = rd_data;

  // INIT entry k: head k cleared, then node j's next word chained to node j+1.
  assign init_node = init_cnt - ADDR_WIDTH'(NUM_LISTS);
  assign init_addr = (init_cnt < ADDR_WIDTH'(NUM_LISTS)) ? init_cnt
                   : ADDR_WIDTH'(NODE_BASE) + (init_node << 1) + ONE;
  assign init_link = ((init_cnt < ADDR_WIDTH'(NUM_LISTS)) || (init_cnt == INIT_LEN - ONE))
                   ? '0 : init_addr + ONE;

`ifdef LINK_LIST_LEN_EN
  logic [IDX_WIDTH:0]    len [NUM_LISTS];
  logic [LIST_WIDTH-1:0] list;
  logic                  len_inc, len_dec, early_err;

  assign early_err = (order_op == OP_INSERT) ? ({1'b0, order_idx} >  len[order_list])
                                             : ({1'b0, order_idx} >= len[order_list]);
  assign resp_len  = resp_valid ? len[list] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list <= '0;
      for (int i = 0; i < NUM_LISTS; i++) len[i] <= '0;
    end else begin
      if (state == S_IDLE && order_valid) list <= order_list;
      if (state == S_INIT) begin
        for (int i = 0; i < NUM_LISTS; i++) len[i] <= '0;
      end else if (len_inc) begin
        len[list] <= len[list] + (IDX_WIDTH+1)'(1);
      end else if (len_dec) begin
        len[list] <= len[list] - (IDX_WIDTH+1)'(1);
      end
    end
  end
`endif

  always_comb begin
    state_d     = state;     init_cnt_d = init_cnt; init_done_d = init_done;
    free_head_d = free_head; op_d       = op;       idx_d       = idx;
    data_d      = data;      p_d        = p;        t_d         = t;
    cnt_d       = cnt;       aux_d      = aux;      rd_data_d   = rd_data;
    status_d    = status;
`ifdef LINK_LIST_LEN_EN
    len_inc = 1'b0;
    len_dec = 1'b0;
`endif
    case (state)
      S_INIT: begin
        if (init_cnt == INIT_LEN) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
          free_head_d = ADDR_WIDTH'(NODE_BASE);
        end else begin
          init_cnt_d = init_cnt + ONE;
        end
      end
      S_IDLE: begin
        if (order_valid && order_ready) begin
          op_d      = order_op;
          idx_d     = order_idx;
          data_d    = order_data;
          p_d       = ADDR_WIDTH'(order_list);
          t_d       = '0;
          cnt_d     = '0;
          rd_data_d = '0;
          status_d  = ST_OK;
          state_d   = S_WALK_ISS;
`ifdef LINK_LIST_LEN_EN
          if (early_err) begin
            status_d = ST_RANGE;
            state_d  = S_RESP;
          end
`endif
        end
      end
      S_WALK_ISS: state_d = S_WALK_CAP;
      S_WALK_CAP: begin
        // After idx hops, the word at p is the link to the target (or the insertion point).
        if (cnt == idx) begin
          t_d = rd_link;
          if (op != OP_INSERT && rd_link == '0) begin
            status_d = ST_RANGE;
            state_d  = S_RESP;
          end else if (op == OP_INSERT && free_head == '0) begin
            status_d = ST_FULL;
            state_d  = S_RESP;
          end else begin
            state_d = S_RD0_ISS;
          end
        end else if (rd_link == '0) begin
          status_d = ST_RANGE;
          state_d  = S_RESP;
        end else begin
          p_d     = rd_link + ONE;
          cnt_d   = cnt + IDX_WIDTH'(1);
          state_d = S_WALK_ISS;
        end
      end
      S_RD0_ISS: state_d = S_RD0_CAP;
      S_RD0_CAP: begin
        case (op)
          OP_INSERT: begin aux_d = rd_link; state_d = S_WR0; end
          OP_DELETE: begin rd_data_d = ram_rdata; state_d = S_RD1_ISS; end
          OP_WRITE:  begin rd_data_d = ram_rdata; state_d = S_WR0; end
          default:   begin rd_data_d = ram_rdata; state_d = S_RESP; end
        endcase
      end
      S_RD1_ISS: state_d = S_RD1_CAP;
      S_RD1_CAP: begin aux_d = rd_link; state_d = S_WR0; end
      S_WR0:     state_d = (op == OP_WRITE) ? S_RESP : S_WR1;
      S_WR1: begin
        if (op == OP_DELETE) begin
          free_head_d = t;
          state_d     = S_RESP;
`ifdef LINK_LIST_LEN_EN
          len_dec = 1'b1;
`endif
        end else begin
          state_d = S_WR2;
        end
      end
      S_WR2: begin
        free_head_d = aux;
        state_d     = S_RESP;
`ifdef LINK_LIST_LEN_EN
        len_inc = 1'b1;
`endif
      end
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM strobes are registered: drive them from the state being entered and its register values.
  always_comb begin
    addr_d  = '0;
    we_d    = 1'b0;
    wdata_d = '0;
    case (state_d)
      S_INIT: begin
        we_d    = 1'b1;
        addr_d  = init_addr;
        wdata_d = DATA_WIDTH'(init_link);
      end
      S_WALK_ISS: addr_d = p_d;
      S_RD0_ISS:  addr_d = (op_d == OP_INSERT) ? free_head_d + ONE : t_d;
      S_RD1_ISS:  addr_d = t_d + ONE;
      S_WR0: begin
        we_d = 1'b1;
        case (op_d)
          OP_INSERT: begin addr_d = free_head_d; wdata_d = data_d; end
          OP_DELETE: begin addr_d = p_d; wdata_d = DATA_WIDTH'(aux_d); end
          default:   begin addr_d = t_d; wdata_d = data_d; end
        endcase
      end
      S_WR1: begin
        we_d = 1'b1;
        if (op_d == OP_DELETE) begin
          addr_d  = t_d + ONE;
          wdata_d = DATA_WIDTH'(free_head_d);
        end else begin
          addr_d  = free_head_d + ONE;
          wdata_d = DATA_WIDTH'(t_d);
        end
      end
      S_WR2: begin
        we_d    = 1'b1;
        addr_d  = p_d;
        wdata_d = DATA_WIDTH'(free_head_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;  init_cnt <= '0; init_done <= 1'b0; free_head <= '0;
      op    <= '0;      idx      <= '0; data      <= '0;   p         <= '0;
      t     <= '0;      cnt      <= '0; aux       <= '0;   rd_data   <= '0;
      status <= '0;     ram_addr <= '0; ram_we    <= 1'b0; ram_wdata <= '0;
    end else begin
      state <= state_d; init_cnt <= init_cnt_d; init_done <= init_done_d; free_head <= free_head_d;
      op    <= op_d;    idx      <= idx_d;      data      <= data_d;      p         <= p_d;
      t     <= t_d;     cnt      <= cnt_d;      aux       <= aux_d;       rd_data   <= rd_data_d;
      status <= status_d; ram_addr <= addr_d;   ram_we    <= we_d;        ram_wdata <= wdata_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_link_list_engine.sv
`default_nettype none
// Directed self-checking bench for link_list_engine: 4 lists, 4 nodes, default build, behavioural RAM.
module tb_link_list_engine;
  localparam logic [1:0] INS = 2'b00, DEL = 2'b01, WR = 2'b10, RD = 2'b11;
  localparam logic [1:0] OK = 2'b00, ERNG = 2'b01, EFULL = 2'b10;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        init_done, order_valid, order_ready, resp_valid, resp_ready, ram_we;
  logic [1:0]  order_op, order_list, resp_status;
  logic [7:0]  order_idx;
  logic [15:0] order_data, resp_data, ram_addr, ram_wdata, ram_rdata;

  link_list_engine #(.NUM_NODES(4)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .order_valid(order_valid), .order_ready(order_ready), .order_op(order_op),
    .order_list(order_list), .order_idx(order_idx), .order_data(order_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .resp_data(resp_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[5:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[5:0]];
  end

  int   we_count = 0;
  logic both_seen = 1'b0;
  always @(posedge clk) if (ram_we) we_count <= we_count + 1;
  always @(negedge clk) if (resp_valid && order_ready) both_seen <= 1'b1;

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_init(output int cyc);
    cyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (init_done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] lst, input logic [7:0] idx,
                     input logic [15:0] dat, output logic [1:0] st, output logic [15:0] rd,
                     output int writes);
    int w0, tmo;
    @(negedge clk);
    order_op = op; order_list = lst; order_idx = idx; order_data = dat; order_valid = 1'b1;
    tmo = 0;
    while (!order_ready && tmo < 50) begin @(negedge clk); tmo++; end
    if (!order_ready) check_eq("accept_timeout", 0, 1);
    w0 = we_count;
    @(negedge clk);
    order_valid = 1'b0;
    tmo = 0;
    while (!resp_valid && tmo < 200) begin @(negedge clk); tmo++; end
    if (!resp_valid) check_eq("resp_timeout", 0, 1);
    st = resp_status;
    rd = resp_data;
    writes = we_count - w0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [1:0] lst,
                     input logic [7:0] idx, input logic [15:0] dat,
                     input logic [1:0] exp_st, input logic [15:0] exp_rd, input int exp_wr);
    logic [1:0]  st;
    logic [15:0] rd;
    int          wr;
    cmd(op, lst, idx, dat, st, rd, wr);
    check_eq({tag, ".status"}, 64'(st), 64'(exp_st));
    check_eq({tag, ".data"},   64'(rd), 64'(exp_rd));
    check_eq({tag, ".writes"}, 64'(wr), 64'(exp_wr));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq(tag, 64'({init_done, order_ready, resp_valid, resp_status, resp_data,
                       ram_addr, ram_we, ram_wdata}), 64'd0);
  endtask

  int cyc, w0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hDEAD;
    order_valid = 1'b0; order_op = '0; order_list = '0; order_idx = '0; order_data = '0;
    resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    w0 = we_count;
    rst_n = 1'b1;
    wait_init(cyc);
    check_eq("init_cycle", 64'(cyc), 64'd8);
    check_eq("init_writes", 64'(we_count - w0), 64'd8);
    check_eq("init_ready", 64'(order_ready), 64'd1);
    check_eq("init_heads", {mem[0], mem[1], mem[2], mem[3]}, 64'd0);
    check_eq("init_nexts", {mem[5], mem[7], mem[9], mem[11]}, {16'd6, 16'd8, 16'd10, 16'd0});

    run("ins_a", INS, 2'd1, 8'd0, 16'hAAAA, OK, 16'h0000, 3);
    run("ins_b", INS, 2'd1, 8'd1, 16'hBBBB, OK, 16'h0000, 3);
    run("ins_c", INS, 2'd1, 8'd1, 16'hCCCC, OK, 16'h0000, 3);
    run("rd0",   RD,  2'd1, 8'd0, 16'h0,    OK, 16'hAAAA, 0);
    run("rd1",   RD,  2'd1, 8'd1, 16'h0,    OK, 16'hCCCC, 0);
    run("rd2",   RD,  2'd1, 8'd2, 16'h0,    OK, 16'hBBBB, 0);
    run("rd3_past_end", RD, 2'd1, 8'd3, 16'h0, ERNG, 16'h0000, 0);

    run("del1",  DEL, 2'd1, 8'd1, 16'h0,    OK, 16'hCCCC, 2);
    run("rd1_after_del", RD, 2'd1, 8'd1, 16'h0, OK, 16'hBBBB, 0);
    run("ins_tail_reuse", INS, 2'd1, 8'd2, 16'hDDDD, OK, 16'h0000, 3);
    check_eq("reused_node_data", 64'(mem[8]), 64'h0000_0000_0000_DDDD);
    run("wr0",   WR,  2'd1, 8'd0, 16'hEEEE, OK, 16'hAAAA, 1);
    run("rd0_after_wr", RD, 2'd1, 8'd0, 16'h0, OK, 16'hEEEE, 0);

    run("ins_last_node", INS, 2'd0, 8'd0, 16'h1111, OK, 16'h0000, 3);
    run("ins_full",      INS, 2'd0, 8'd0, 16'h2222, EFULL, 16'h0000, 0);
    run("ins_full_range", INS, 2'd0, 8'd2, 16'h3333, ERNG, 16'h0000, 0);
    run("rd_list0",      RD,  2'd0, 8'd0, 16'h0, OK, 16'h1111, 0);

    run("rd_empty",      RD,  2'd2, 8'd0, 16'h0,    ERNG, 16'h0000, 0);
    run("ins_empty_idx1", INS, 2'd2, 8'd1, 16'h4444, ERNG, 16'h0000, 0);
    run("del_empty",     DEL, 2'd2, 8'd0, 16'h0,    ERNG, 16'h0000, 0);
    run("wr_past_end",   WR,  2'd1, 8'd3, 16'h5555, ERNG, 16'h0000, 0);
    run("del_tail",      DEL, 2'd1, 8'd2, 16'h0,    OK,   16'hDDDD, 2);
    run("ins_after_free", INS, 2'd3, 8'd0, 16'h6666, OK,  16'h0000, 3);
    check_eq("refill_node_data", 64'(mem[8]), 64'h0000_0000_0000_6666);

    // Abort a READ mid-walk with reset while resp_ready stays low.
    @(negedge clk);
    order_op = RD; order_list = 2'd1; order_idx = 8'd2; order_valid = 1'b1; resp_ready = 1'b0;
    @(negedge clk);
    order_valid = 1'b0;
    @(negedge clk);
    check_eq("walk_in_progress", 64'(resp_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_walk");
    @(negedge clk);
    w0 = we_count;
    rst_n = 1'b1;
    wait_init(cyc);
    check_eq("reinit_cycle", 64'(cyc), 64'd8);
    check_eq("reinit_writes", 64'(we_count - w0), 64'd8);
    for (int l = 0; l < 4; l++)
      run($sformatf("empty_after_reset_l%0d", l), RD, 2'(l), 8'd0, 16'h0, ERNG, 16'h0000, 0);
    run("ins_after_reset", INS, 2'd0, 8'd0, 16'h7777, OK, 16'h0000, 3);
    check_eq("first_node_after_reset", 64'(mem[4]), 64'h0000_0000_0000_7777);

    check_eq("ready_valid_exclusive", 64'(both_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
